// File: rtl/round_key_lifo.sv
// -----------------------------------------------------------------------------
// round_key_lifo
//
// Purpose:
//   Stores the NUM_KEYS round keys produced by an AES key expansion (round 0
//   first) and replays them in reverse order (highest round first) for the
//   inverse cipher. Three states: LOAD (accepting keys), FULL (all keys held,
//   waiting for start) and DRAIN (presenting keys with a valid/ready handshake).
//
// Optional feature (compile-time macro KEY_REPLAY_EN):
//   defined   - after the round 0 key is taken the block returns to FULL with
//               the keys retained, so a further start replays the schedule.
//   undefined - after the round 0 key is taken the block returns to LOAD and
//               a full reload is needed before the next readout.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            synchronous active-high reset
//   i_key_in_valid   producer offers i_key_in
//   i_key_in         128-bit round key, round 0 first
//   o_key_in_ready   block accepts i_key_in this cycle
//   i_flush          abort: discard progress, return to LOAD
//   i_start          request reverse-order readout (honoured only in FULL)
//   o_loaded         all keys held and no readout in progress
//   o_key_out_valid  o_key_out holds a valid round key
//   o_key_out        128-bit round key, highest round first
//   i_key_out_ready  consumer accepts o_key_out
//   o_round_idx      round number of o_key_out
//   o_last           o_key_out is the round 0 key
// -----------------------------------------------------------------------------
module round_key_lifo #(
    parameter int unsigned NUM_KEYS = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_key_in_valid,
    input  logic [127:0] i_key_in,
    output logic         o_key_in_ready,
    input  logic         i_flush,
    input  logic         i_start,
    output logic         o_loaded,
    output logic         o_key_out_valid,
    output logic [127:0] o_key_out,
    input  logic         i_key_out_ready,
    output logic [3:0]   o_round_idx,
    output logic         o_last
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t         r_state;
    logic [3:0]     r_wr_cnt;
    logic [3:0]     r_rd_ptr;
    logic           r_key_in_ready;
    logic           r_loaded;
    logic           r_key_out_valid;
    logic [127:0]   r_key_out;
    logic [3:0]     r_round_idx;
    logic           r_last;
    logic [127:0]   r_mem [NUM_KEYS];

    logic           w_in_xfer;
    logic           w_out_xfer;
    logic           w_mem_we;
    logic [3:0]     w_rd_next;

    // r_key_in_ready is only ever set while in LOAD, so it doubles as the state qualifier
    assign w_in_xfer  = i_key_in_valid & r_key_in_ready;
    assign w_out_xfer = r_key_out_valid & i_key_out_ready;
    // A transfer coinciding with flush or reset is discarded entirely
    assign w_mem_we   = w_in_xfer & ~i_flush & ~i_rst;
    assign w_rd_next  = r_rd_ptr - 4'd1;

    // Ready is forced low for the whole time reset is held, and comes back
    // the first cycle reset is released because the register resets to 1
    assign o_key_in_ready  = r_key_in_ready & ~i_rst;
    assign o_loaded        = r_loaded;
    assign o_key_out_valid = r_key_out_valid;
    assign o_key_out       = r_key_out;
    assign o_round_idx     = r_round_idx;
    assign o_last          = r_last;

    // Key storage: written in LOAD order, never cleared (only counters are reset)
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_cnt] <= i_key_in;
        end
    end

    // Control FSM with all handshake outputs registered alongside the state
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            // Reset and flush have the same effect; reset simply has priority
            r_state         <= ST_LOAD;
            r_wr_cnt        <= 4'd0;
            r_rd_ptr        <= 4'd0;
            r_key_in_ready  <= 1'b1;
            r_loaded        <= 1'b0;
            r_key_out_valid <= 1'b0;
            r_key_out       <= 128'd0;
            r_round_idx     <= 4'd0;
            r_last          <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_in_xfer) begin
                        if (r_wr_cnt == LAST_IDX) begin
                            r_state        <= ST_FULL;
                            r_wr_cnt       <= 4'd0;
                            r_key_in_ready <= 1'b0;
                            r_loaded       <= 1'b1;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + 4'd1;
                        end
                    end
                end
                ST_FULL: begin
                    if (i_start) begin
                        // Present the highest round key on the very next cycle
                        r_state         <= ST_DRAIN;
                        r_rd_ptr        <= LAST_IDX;
                        r_loaded        <= 1'b0;
                        r_key_out_valid <= 1'b1;
                        r_key_out       <= r_mem[LAST_IDX];
                        r_round_idx     <= LAST_IDX;
                        r_last          <= (LAST_IDX == 4'd0);
                    end
                end
                ST_DRAIN: begin
                    if (w_out_xfer) begin
                        if (r_rd_ptr == 4'd0) begin
                            r_rd_ptr        <= 4'd0;
                            r_key_out_valid <= 1'b0;
                            r_key_out       <= 128'd0;
                            r_round_idx     <= 4'd0;
                            r_last          <= 1'b0;
`ifdef KEY_REPLAY_EN
                            // Keys are kept; another start replays them
                            r_state        <= ST_FULL;
                            r_loaded       <= 1'b1;
                            r_key_in_ready <= 1'b0;
`else
                            r_state        <= ST_LOAD;
                            r_wr_cnt       <= 4'd0;
                            r_loaded       <= 1'b0;
                            r_key_in_ready <= 1'b1;
`endif
                        end else begin
                            // Storage is static while draining, so the next key can be
                            // fetched directly and held until the consumer takes it
                            r_rd_ptr    <= w_rd_next;
                            r_key_out   <= r_mem[w_rd_next];
                            r_round_idx <= w_rd_next;
                            r_last      <= (r_rd_ptr == 4'd1);
                        end
                    end
                end
                default: begin
                    r_state         <= ST_LOAD;
                    r_wr_cnt        <= 4'd0;
                    r_rd_ptr        <= 4'd0;
                    r_key_in_ready  <= 1'b1;
                    r_loaded        <= 1'b0;
                    r_key_out_valid <= 1'b0;
                    r_key_out       <= 128'd0;
                    r_round_idx     <= 4'd0;
                    r_last          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_key_lifo.sv
// -----------------------------------------------------------------------------
// tb_round_key_lifo
//
// Self-checking bench for round_key_lifo. The stimulus side pushes the expected
// readout (the loaded keys in reverse round order) into a queue when it issues
// start; an independent monitor pops and compares on every output transfer,
// and also checks the idle-zero and stall-stability rules every cycle.
// -----------------------------------------------------------------------------
module tb_round_key_lifo;

    localparam int NK = 11;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_key_in_valid = 1'b0;
    logic [127:0] i_key_in = 128'd0;
    logic         o_key_in_ready;
    logic         i_flush = 1'b0;
    logic         i_start = 1'b0;
    logic         o_loaded;
    logic         o_key_out_valid;
    logic [127:0] o_key_out;
    logic         i_key_out_ready = 1'b0;
    logic [3:0]   o_round_idx;
    logic         o_last;

    round_key_lifo #(.NUM_KEYS(NK)) dut (
        .i_clk           (clk),
        .i_rst           (i_rst),
        .i_key_in_valid  (i_key_in_valid),
        .i_key_in        (i_key_in),
        .o_key_in_ready  (o_key_in_ready),
        .i_flush         (i_flush),
        .i_start         (i_start),
        .o_loaded        (o_loaded),
        .o_key_out_valid (o_key_out_valid),
        .o_key_out       (o_key_out),
        .i_key_out_ready (i_key_out_ready),
        .o_round_idx     (o_round_idx),
        .o_last          (o_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   idx;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] src_keys [NK];
    int           n_pass = 0;
    int           n_total = 0;
    bit           mon_on = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int mode, input int cyc);
        logic [3:0] pat;
        pat = 4'b1001; // pat[0..3] = 1,0,0,1
        case (mode)
            0:       return 1'b1;
            1:       return pat[2'((cyc - 1) % 4)];
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_fips();
        src_keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        src_keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        src_keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        src_keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        src_keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        src_keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        src_keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        src_keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        src_keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        src_keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        src_keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    endtask

    task automatic set_random();
        for (int i = 0; i < NK; i++) src_keys[i] = rnd128();
    endtask

    // Offer src_keys[first .. first+cnt-1], optionally with idle gaps
    task automatic load_keys(input int first, input int cnt, input bit gaps);
        for (int i = first; i < first + cnt; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    i_key_in_valid = 1'b0;
                    i_key_in = rnd128();
                    tick();
                end
            end
            i_key_in_valid = 1'b1;
            i_key_in = src_keys[i];
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!o_key_in_ready && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 20) check("load_ready_timeout", 128'(o_key_in_ready), 128'd1);
            end
            tick();
        end
        i_key_in_valid = 1'b0;
    endtask

    task automatic do_flush();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        exp_q.delete();
        check("flush_in_ready", 128'(o_key_in_ready), 128'd1);
        check("flush_loaded", 128'(o_loaded), 128'd0);
        check("flush_out_valid", 128'(o_key_out_valid), 128'd0);
    endtask

    task automatic push_expected();
        exp_t e;
        for (int i = NK - 1; i >= 0; i--) begin
            e.key = src_keys[i];
            e.idx = 4'(i);
            exp_q.push_back(e);
        end
    endtask

    // Full readout from FULL; mode 0 = ready held 1, 1 = 1,0,0,1 pattern, 2 = random
    task automatic readout(input int mode);
        int cyc;
        push_expected();
        i_start = 1'b1;
        i_key_out_ready = rdy(mode, 0);
        tick();
        i_start = 1'b0;
        check("first_valid", 128'(o_key_out_valid), 128'd1);
        check("first_idx", 128'(o_round_idx), 128'd10);
        check("first_key", o_key_out, src_keys[NK - 1]);
        cyc = 1;
        while ((exp_q.size() != 0 || o_key_out_valid) && cyc < 200) begin
            i_key_out_ready = rdy(mode, cyc);
            tick();
            cyc++;
        end
        check("drain_done", 128'(exp_q.size()), 128'd0);
        check("drain_valid_low", 128'(o_key_out_valid), 128'd0);
        if (mode == 0) check("back_to_back_cycles", 128'(cyc - 1), 128'(NK));
`ifdef KEY_REPLAY_EN
        check("after_drain_loaded", 128'(o_loaded), 128'd1);
        check("after_drain_in_ready", 128'(o_key_in_ready), 128'd0);
`else
        check("after_drain_loaded", 128'(o_loaded), 128'd0);
        check("after_drain_in_ready", 128'(o_key_in_ready), 128'd1);
`endif
        i_key_out_ready = 1'b0;
    endtask

    // Monitor: scoreboard compare on output transfers, idle-zero and stall rules
    initial begin
        exp_t         e;
        bit           prev_stall;
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        prev_stall = 1'b0;
        prev_key = 128'd0;
        prev_idx = 4'd0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (o_key_out_valid) begin
                    if (prev_stall) begin
                        check("stall_key_stable", o_key_out, prev_key);
                        check("stall_idx_stable", 128'(o_round_idx), 128'(prev_idx));
                    end
                    if (i_key_out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_output", 128'(o_round_idx), 128'hffff);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_key", o_key_out, e.key);
                            check("out_idx", 128'(o_round_idx), 128'(e.idx));
                            check("out_last", 128'(o_last), 128'(e.idx == 4'd0));
                        end
                    end
                end else begin
                    check("idle_key_zero", o_key_out, 128'd0);
                    check("idle_idx_zero", 128'(o_round_idx), 128'd0);
                    check("idle_last_zero", 128'(o_last), 128'd0);
                end
                prev_stall = o_key_out_valid && !i_key_out_ready;
                prev_key = o_key_out;
                prev_idx = o_round_idx;
            end
        end
    end

    initial begin
        // Reset behaviour
        #1;
        check("rst_in_ready_low_pre_edge", 128'(o_key_in_ready), 128'd0);
        tick();
        tick();
        check("rst_in_ready_low", 128'(o_key_in_ready), 128'd0);
        check("rst_loaded", 128'(o_loaded), 128'd0);
        check("rst_out_valid", 128'(o_key_out_valid), 128'd0);
        check("rst_key_out", o_key_out, 128'd0);
        check("rst_round_idx", 128'(o_round_idx), 128'd0);
        check("rst_last", 128'(o_last), 128'd0);
        i_rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(o_key_in_ready), 128'd1);
        mon_on = 1'b1;

        // FIPS-197 schedule, back-to-back readout
        set_fips();
        load_keys(0, NK, 1'b0);
        check("fips_loaded", 128'(o_loaded), 128'd1);
        check("fips_full_in_ready", 128'(o_key_in_ready), 128'd0);
        // key_in_valid must be ignored while FULL
        i_key_in_valid = 1'b1;
        i_key_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        tick();
        tick();
        i_key_in_valid = 1'b0;
        check("full_still_loaded", 128'(o_loaded), 128'd1);
        readout(0);

        // Second start after completed readout
`ifdef KEY_REPLAY_EN
        readout(0);
`else
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("restart_ignored_valid", 128'(o_key_out_valid), 128'd0);
        check("restart_ignored_in_ready", 128'(o_key_in_ready), 128'd1);
`endif

        // Stall pattern 1,0,0,1
        do_flush();
        load_keys(0, NK, 1'b0);
        readout(1);

        // start during LOAD is ignored
        do_flush();
        set_random();
        load_keys(0, 5, 1'b1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("load_start_valid", 128'(o_key_out_valid), 128'd0);
        check("load_start_loaded", 128'(o_loaded), 128'd0);
        check("load_start_in_ready", 128'(o_key_in_ready), 128'd1);
        load_keys(5, 6, 1'b0);
        check("load_11_loaded", 128'(o_loaded), 128'd1);
        readout(0);

        // flush during DRAIN at round 6
        do_flush();
        set_fips();
        load_keys(0, NK, 1'b0);
        push_expected();
        i_key_out_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        begin
            int n;
            n = 0;
            while (o_round_idx != 4'd6 && n < 20) begin
                tick();
                n++;
            end
            check("reach_round6", 128'(o_round_idx), 128'd6);
        end
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        exp_q.delete();
        check("drain_flush_valid", 128'(o_key_out_valid), 128'd0);
        check("drain_flush_in_ready", 128'(o_key_in_ready), 128'd1);
        check("drain_flush_loaded", 128'(o_loaded), 128'd0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("flush_no_readout", 128'(o_key_out_valid), 128'd0);

        // reset for one cycle mid-DRAIN
        load_keys(0, NK, 1'b0);
        push_expected();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        exp_q.delete();
        check("mid_rst_in_ready", 128'(o_key_in_ready), 128'd0);
        check("mid_rst_valid", 128'(o_key_out_valid), 128'd0);
        check("mid_rst_key", o_key_out, 128'd0);
        check("mid_rst_idx", 128'(o_round_idx), 128'd0);
        check("mid_rst_last", 128'(o_last), 128'd0);
        check("mid_rst_loaded", 128'(o_loaded), 128'd0);
        i_rst = 1'b0;
        #1;
        check("mid_rst_release_ready", 128'(o_key_in_ready), 128'd1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("mid_rst_no_readout", 128'(o_key_out_valid), 128'd0);
        set_random();
        load_keys(0, NK - 1, 1'b1);
        check("reload_10_not_loaded", 128'(o_loaded), 128'd0);
        load_keys(NK - 1, 1, 1'b0);
        check("reload_11_loaded", 128'(o_loaded), 128'd1);
        readout(2);

        // Randomized load/readout rounds
        for (int r = 0; r < 4; r++) begin
            do_flush();
            set_random();
            load_keys(0, NK, 1'b1);
            check("rand_loaded", 128'(o_loaded), 128'd1);
            readout(2);
        end

        tick();
        tick();
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
